// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter and run control for the miniMips core.
// Optional return-address stack enabled by defining macro RAS_EN.
module pc_sequencer #(
  parameter int                 PC_W        = 8,
  parameter int                 INSTR_W     = 9,
  parameter logic [INSTR_W-1:0] HALT_OPCODE = 9'b101100100,
  parameter int                 CNT_W       = 16,
  parameter int                 RAS_DEPTH   = 4
) (
  input  logic               clk,
  input  logic               start,
  input  logic [INSTR_W-1:0] instr,
  input  logic               stall,
  input  logic               branch,
  input  logic [PC_W-1:0]    jump_amount,
  input  logic               call,
  input  logic               ret,
  output logic [PC_W-1:0]    pc,
  output logic               running,
  output logic               done,
  output logic               pc_wrap,
  output logic               ras_err,
  output logic [CNT_W-1:0]   cycle_count
);

  typedef enum logic [1:0] {
    S_RESET,
    S_RUN,
    S_HALT
  } state_e;

  localparam logic [PC_W-1:0]  PC_ONE  = {{(PC_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e            state_q, state_d, cur;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [PC_W-1:0]   pc_inc, pc_br;
  logic              inc_carry;
  logic              done_q, done_d;
  logic              wrap_q, wrap_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              is_halt;

  assign {inc_carry, pc_inc} = {1'b0, pc_q} + {1'b0, PC_ONE};
  assign pc_br   = pc_q + jump_amount;
  assign is_halt = (instr == HALT_OPCODE);

`ifdef RAS_EN
  localparam int              SP_W    = $clog2(RAS_DEPTH + 1);
  localparam logic [SP_W-1:0] SP_ONE  = SP_W'(1);
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(RAS_DEPTH);

  logic [SP_W-1:0] sp_q, sp_d;
  logic [PC_W-1:0] ras_q [RAS_DEPTH];
  logic [PC_W-1:0] top_val;
  logic            push_en;

  // Read the top-of-stack entry (the one below the pointer)
  always_comb begin
    top_val = '0;
    for (int i = 0; i < RAS_DEPTH; i++) begin
      if (SP_W'(i) == sp_q - SP_ONE) top_val = ras_q[i];
    end
  end

  // Stack storage; pointer cleared on start, entries kept
  always_ff @(posedge clk) begin
    if (start) begin
      sp_q <= '0;
    end else begin
      sp_q <= sp_d;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        if (push_en && SP_W'(i) == sp_q) ras_q[i] <= pc_inc;
      end
    end
  end
`else
  logic unused_ok;
  assign unused_ok = ^{call, ret, (RAS_DEPTH > 0)};
`endif

  // Effective state: start overrides everything as RESET
  always_comb begin
    cur = start ? S_RESET : state_q;
  end

  // Next-state, next-PC and sticky flag logic
  always_comb begin
    state_d = cur;
    pc_d    = pc_q;
    done_d  = done_q;
    wrap_d  = wrap_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
`ifdef RAS_EN
    sp_d    = sp_q;
    push_en = 1'b0;
`endif
    unique case (cur)
      S_RESET: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_ONE;
        if (stall) begin
          pc_d = pc_q;
        end else if (is_halt) begin
          state_d = S_HALT;
          done_d  = 1'b1;
        end
`ifdef RAS_EN
        else if (ret) begin
          if (sp_q != '0) begin
            pc_d = top_val;
            sp_d = sp_q - SP_ONE;
          end else begin
            pc_d  = pc_inc;
            err_d = 1'b1;
          end
        end else if (call) begin
          pc_d = pc_br;
          if (sp_q != SP_FULL) begin
            push_en = 1'b1;
            sp_d    = sp_q + SP_ONE;
          end else begin
            err_d = 1'b1;
          end
        end
`endif
        else if (branch) begin
          pc_d = pc_br;
        end else begin
          pc_d = pc_inc;
          if (inc_carry) wrap_d = 1'b1;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_RESET;
      end
    endcase
  end

  // State and datapath registers with synchronous start reset
  always_ff @(posedge clk) begin
    if (start) begin
      state_q <= S_RUN;
      pc_q    <= '0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc          = pc_q;
  assign running     = (cur == S_RUN);
  assign done        = done_q;
  assign pc_wrap     = wrap_q;
  assign ras_err     = err_q;
  assign cycle_count = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed self-checking bench for pc_sequencer.
// Covers RAS_EN tests when that macro is defined.
module tb_pc_sequencer;

  localparam logic [8:0] HALT = 9'b101100100;

  logic        clk = 1'b0;
  logic        start = 1'b1;
  logic [8:0]  instr = '0;
  logic        stall = 1'b0;
  logic        branch = 1'b0;
  logic [7:0]  jump_amount = '0;
  logic        call = 1'b0;
  logic        ret = 1'b0;
  logic [7:0]  pc;
  logic        running;
  logic        done;
  logic        pc_wrap;
  logic        ras_err;
  logic [15:0] cycle_count;

  int checks = 0;
  int errors = 0;

  pc_sequencer dut (
    .clk(clk), .start(start), .instr(instr), .stall(stall),
    .branch(branch), .jump_amount(jump_amount), .call(call),
    .ret(ret), .pc(pc), .running(running), .done(done),
    .pc_wrap(pc_wrap), .ras_err(ras_err), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    instr = '0; stall = 0; branch = 0; jump_amount = '0;
    call = 0; ret = 0;
    start = 1;
    tick();
    tick();
    start = 0;
  endtask

  task automatic test_reset();
    start = 1;
    tick();
    tick();
    checks++; if (pc !== 8'd0) begin errors++; $display("FAIL reset_pc got %0d want 0", pc); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running got %b want 0", running); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (cycle_count !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", cycle_count); end
    checks++; if ({pc_wrap, ras_err} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b want 00", {pc_wrap, ras_err}); end
    start = 0;
    #1;
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL run_after_start got %b want 1", running); end
  endtask

  task automatic test_seq_halt();
    do_start();
    for (int i = 0; i < 7; i++) begin
      checks++; if (pc !== 8'(i)) begin errors++; $display("FAIL seq_pc got %0d want %0d", pc, i); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL seq_done_early at %0d got %b want 0", i, done); end
      instr = (i == 6) ? HALT : 9'h011;
      tick();
    end
    instr = 9'h000;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL halt_done got %b want 1", done); end
    checks++; if (pc !== 8'd6) begin errors++; $display("FAIL halt_pc got %0d want 6", pc); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL halt_running got %b want 0", running); end
    checks++; if (cycle_count !== 16'd7) begin errors++; $display("FAIL halt_cnt got %0d want 7", cycle_count); end
    branch = 1; jump_amount = 8'd3;
    repeat (3) tick();
    branch = 0;
    checks++; if (pc !== 8'd6) begin errors++; $display("FAIL halt_frozen_pc got %0d want 6", pc); end
    checks++; if (cycle_count !== 16'd7) begin errors++; $display("FAIL halt_frozen_cnt got %0d want 7", cycle_count); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL halt_sticky got %b want 1", done); end
  endtask

  task automatic test_branch();
    do_start();
    repeat (10) tick();
    checks++; if (pc !== 8'd10) begin errors++; $display("FAIL br_pre_pc got %0d want 10", pc); end
    branch = 1; jump_amount = 8'hFD;
    tick();
    checks++; if (pc !== 8'd7) begin errors++; $display("FAIL br_back_pc got %0d want 7", pc); end
    checks++; if (pc_wrap !== 1'b0) begin errors++; $display("FAIL br_no_wrap got %b want 0", pc_wrap); end
    jump_amount = 8'd248;
    tick();
    checks++; if (pc !== 8'd255) begin errors++; $display("FAIL br_fwd_pc got %0d want 255", pc); end
    branch = 0;
    tick();
    checks++; if (pc !== 8'd0) begin errors++; $display("FAIL wrap_pc got %0d want 0", pc); end
    checks++; if (pc_wrap !== 1'b1) begin errors++; $display("FAIL wrap_flag got %b want 1", pc_wrap); end
    checks++; if (cycle_count !== 16'd13) begin errors++; $display("FAIL br_cnt got %0d want 13", cycle_count); end
    branch = 1; jump_amount = 8'd0;
    tick();
    branch = 0;
    checks++; if (pc !== 8'd0) begin errors++; $display("FAIL selfloop_pc got %0d want 0", pc); end
    checks++; if (cycle_count !== 16'd14) begin errors++; $display("FAIL selfloop_cnt got %0d want 14", cycle_count); end
    tick();
    checks++; if (pc_wrap !== 1'b1) begin errors++; $display("FAIL wrap_sticky got %b want 1", pc_wrap); end
  endtask

  task automatic test_stall_halt();
    do_start();
    repeat (4) tick();
    stall = 1; branch = 1; jump_amount = 8'd7;
    repeat (3) tick();
    checks++; if (pc !== 8'd4) begin errors++; $display("FAIL stall_pc got %0d want 4", pc); end
    checks++; if (cycle_count !== 16'd7) begin errors++; $display("FAIL stall_cnt got %0d want 7", cycle_count); end
    stall = 0; jump_amount = 8'd2;
    tick();
    branch = 0;
    checks++; if (pc !== 8'd6) begin errors++; $display("FAIL unstall_pc got %0d want 6", pc); end
    instr = HALT; stall = 1;
    repeat (2) tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL stall_halt_done got %b want 0", done); end
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL stall_halt_run got %b want 1", running); end
    stall = 0;
    tick();
    instr = '0;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL late_halt_done got %b want 1", done); end
    checks++; if (pc !== 8'd6) begin errors++; $display("FAIL late_halt_pc got %0d want 6", pc); end
    checks++; if (cycle_count !== 16'd11) begin errors++; $display("FAIL late_halt_cnt got %0d want 11", cycle_count); end
  endtask

  task automatic test_reset_mid();
    do_start();
    stall = 1;
    repeat (3) tick();
    stall = 0;
    repeat (37) tick();
    checks++; if (pc !== 8'd37) begin errors++; $display("FAIL mid_pre_pc got %0d want 37", pc); end
    checks++; if (cycle_count !== 16'd40) begin errors++; $display("FAIL mid_pre_cnt got %0d want 40", cycle_count); end
    start = 1;
    tick();
    checks++; if (pc !== 8'd0) begin errors++; $display("FAIL mid_pc got %0d want 0", pc); end
    checks++; if (cycle_count !== 16'd0) begin errors++; $display("FAIL mid_cnt got %0d want 0", cycle_count); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL mid_running got %b want 0", running); end
    start = 0;
    instr = HALT;
    tick();
    instr = '0;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL rehalt_done got %b want 1", done); end
    start = 1;
    tick();
    start = 0;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL restart_done got %b want 0", done); end
    repeat (2) tick();
    checks++; if (pc !== 8'd2) begin errors++; $display("FAIL rerun_pc got %0d want 2", pc); end
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL rerun_running got %b want 1", running); end
  endtask

  task automatic test_ras();
    do_start();
`ifdef RAS_EN
    repeat (3) tick();
    call = 1; jump_amount = 8'd10;
    tick();
    checks++; if (pc !== 8'd13) begin errors++; $display("FAIL call_pc got %0d want 13", pc); end
    call = 0; ret = 1;
    tick();
    ret = 0;
    checks++; if (pc !== 8'd4) begin errors++; $display("FAIL ret_pc got %0d want 4", pc); end
    call = 1; jump_amount = 8'd1;
    repeat (4) tick();
    checks++; if (ras_err !== 1'b0) begin errors++; $display("FAIL push4_err got %b want 0", ras_err); end
    tick();
    call = 0;
    checks++; if (ras_err !== 1'b1) begin errors++; $display("FAIL push5_err got %b want 1", ras_err); end
    checks++; if (pc !== 8'd9) begin errors++; $display("FAIL push5_pc got %0d want 9", pc); end
    do_start();
    ret = 1;
    tick();
    ret = 0;
    checks++; if (pc !== 8'd1) begin errors++; $display("FAIL pop_empty_pc got %0d want 1", pc); end
    checks++; if (ras_err !== 1'b1) begin errors++; $display("FAIL pop_empty_err got %b want 1", ras_err); end
`else
    call = 1; ret = 1; jump_amount = 8'd5;
    tick();
    checks++; if (pc !== 8'd1) begin errors++; $display("FAIL noras_ret_pc got %0d want 1", pc); end
    ret = 0;
    tick();
    call = 0;
    checks++; if (pc !== 8'd2) begin errors++; $display("FAIL noras_call_pc got %0d want 2", pc); end
    checks++; if (ras_err !== 1'b0) begin errors++; $display("FAIL noras_err got %b want 0", ras_err); end
`endif
  endtask

  task automatic test_saturate();
    do_start();
    repeat (65534) tick();
    checks++; if (cycle_count !== 16'd65534) begin errors++; $display("FAIL sat_pre got %0d want 65534", cycle_count); end
    tick();
    checks++; if (cycle_count !== 16'hFFFF) begin errors++; $display("FAIL sat_max got %0d want 65535", cycle_count); end
    repeat (3) tick();
    checks++; if (cycle_count !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got %0d want 65535", cycle_count); end
  endtask

  initial begin
    test_reset();
    test_seq_halt();
    test_branch();
    test_stall_halt();
    test_reset_mid();
    test_ras();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised program-counter and run-control unit for the miniMips core. Replaces the inline PC register, the PC adder and the halt decode in the core top level.
- Tracks run state (run / stall / halted) and drives the instruction-memory address.
- Applies sequential or relative-branch PC updates and raises a sticky `done` on the halt opcode.
- Keeps a saturating cycle counter for the testbench.

Parameters:
- PC_W, 8, program counter and branch-offset width in bits.
- INSTR_W, 9, instruction word width.
- HALT_OPCODE, 9'b101100100, instruction encoding that ends the program.
- CNT_W, 16, cycle counter width.
- RAS_DEPTH, 4, return-address-stack entries (used only with RAS_EN).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- start  input  1  synchronous active-high reset; also begins a new program run.
- instr  input  INSTR_W  current instruction from instruction memory (addressed by pc).
- stall  input  1  hold PC this cycle (multi-cycle memory or ALU op).
- branch  input  1  taken-branch indication from the ALU.
- jump_amount  input  PC_W  branch offset, added modulo 2^PC_W.
- call  input  1  push return address and branch (RAS_EN only; otherwise ignored).
- ret  input  1  pop return address into pc (RAS_EN only; otherwise ignored).
- pc  output  PC_W  instruction-memory address.
- running  output  1  high in RUN state.
- done  output  1  sticky program-complete flag.
- pc_wrap  output  1  sticky; a PC update wrapped past 2^PC_W-1.
- ras_err  output  1  sticky; push on full or pop on empty (always 0 without RAS_EN).
- cycle_count  output  CNT_W  cycles spent in RUN, saturating.

Behaviour:
- Reset (start=1, sampled at posedge, any state, any cycle including mid-program):
  - pc=0, done=0, pc_wrap=0, ras_err=0, cycle_count=0.
  - RAS pointer cleared; state=RUN on the following cycle.
  - running=0 while start is high.
- States:
  - RESET: start=1.
  - RUN.
  - HALT.
  - Transitions: RESET->RUN when start falls. RUN->HALT when instr==HALT_OPCODE && !stall. HALT->RESET only via start.
- Next-PC priority in RUN, highest first:
  1. stall: pc holds.
  2. halt opcode: pc holds; done=1 from the next cycle.
  3. ret (RAS_EN).
  4. call (RAS_EN).
  5. branch: pc <= pc + jump_amount.
  6. Otherwise pc <= pc + 1.
- Arithmetic:
  - All additions are unsigned modulo 2^PC_W; a backward branch is encoded as a two's-complement offset.
  - pc_wrap sets only when a sequential +1 increment carries out. Branch-add carries are expected and do not set it.
- jump_amount=0 with branch=1 is legal (self-loop); pc holds and the cycle counts as RUN.
- HALT state:
  - pc frozen at the halt address.
  - done=1, running=0.
  - cycle_count frozen; all other inputs ignored.
- cycle_count:
  - Increments every RUN cycle, including stalled cycles.
  - Saturates at 2^CNT_W-1 with no wrap.
  - The halting cycle counts.
- Latency: pc changes one cycle after the control inputs are sampled. done rises exactly one cycle after the halt instruction is sampled unstalled.
- stall together with halt opcode: no halt until stall drops.

Optional Feature:
- Macro RAS_EN.
- Defined: a RAS_DEPTH-entry return-address stack.
  - call pushes pc+1 (mod 2^PC_W) and branches by jump_amount.
  - ret pops into pc.
  - call and ret together: ret wins, no push.
  - Push when full: entry dropped, ras_err=1, branch still taken.
  - Pop when empty: pc <= pc+1, ras_err=1.
- Undefined: no stack storage; call and ret ignored; ras_err tied 0.

Test Plan:
- Sequential run and halt: start high 2 cycles, then instructions at pc 0..5 non-halt and pc 6 = 9'b101100100 -> pc steps 0..6; done=1 from the cycle after pc=6; pc stays 6; cycle_count=7 and frozen.
- Branch with PC_W=8: at pc=10, branch=1, jump_amount=8'hFD -> pc=7 next cycle; pc_wrap stays 0. Then sequential run from pc=255 -> pc=0 and pc_wrap=1.
- Stall priority: at pc=4, stall=1 and branch=1 for 3 cycles -> pc holds 4 and cycle_count advances by 3. Then stall=0, branch=1, jump_amount=2 -> pc=6.
- Halt under stall: halt opcode with stall=1 for 2 cycles -> done=0. Stall drops -> done=1 the next cycle.
- Reset mid-run: start pulsed at pc=37 with cycle_count=40 -> next cycle pc=0, cycle_count=0, done=0. A second start while in HALT -> done clears and the program reruns from 0.
- RAS_EN, RAS_DEPTH=4: at pc=3, call with jump_amount=10 -> pc=13, then ret -> pc=4. Five nested calls -> ras_err=1 on the fifth. ret on empty stack -> pc+1 and ras_err=1.
